// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and
// the IF/ID pipeline register feeding decode.
// Optional feature macro: IF_PERF_CNT_EN adds the fetch_cnt / stall_cnt
// performance counters and their ports.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_AW   = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_addr,
  output logic [31:0]        irF,
  output logic [31:0]        irD,
  output logic [31:0]        pcD,
  output logic [31:0]        pc4D,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
`endif
  output logic               validD
);

  localparam int unsigned XLEN      = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_next;
  logic            bubble_ifid;
  logic            load_ifid;

  // Next-PC selection and IF/ID update qualifiers; redirect outranks stall.
  always_comb begin
    pc_seq      = pc_addr + PC_STEP;
    pc_next     = pc_addr;
    bubble_ifid = redirect | flush;
    load_ifid   = ~bubble_ifid & ~stall;
    if (redirect) begin
      pc_next = redirect_pc & ALIGN_MASK;
    end else if (!stall) begin
      pc_next = pc_seq;
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_addr <= RESET_PC;
    end else begin
      pc_addr <= pc_next;
    end
  end

  // IF/ID pipeline register; pcD/pc4D keep their value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      irD    <= NOP_INSTR;
      pcD    <= '0;
      pc4D   <= '0;
      validD <= 1'b0;
    end else if (bubble_ifid) begin
      irD    <= NOP_INSTR;
      validD <= 1'b0;
    end else if (load_ifid) begin
      irD    <= irF;
      pcD    <= pc_addr;
      pc4D   <= pc_seq;
      validD <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters: real fetches into IF/ID and non-redirected stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (load_ifid) begin
        fetch_cnt <= fetch_cnt + XLEN'(1);
      end
      if (stall && !redirect) begin
        stall_cnt <= stall_cnt + XLEN'(1);
      end
    end
  end
`endif

  // Word address drops the byte offset and wraps inside the memory.
  assign imem_addr = pc_addr[IMEM_AW+1:2];
  assign irF       = imem_rdata;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a cycle model checked every cycle plus
// hand-computed expectations for the directed scenarios. A second instance
// starts at the top of the address space to exercise PC wrap-around.
module tb_if_stage;

  localparam int unsigned   AW  = 8;
  localparam logic [31:0]   NOP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst, stall, flush, redirect;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr, w_imem_addr;
  logic [31:0]   imem_rdata, w_imem_rdata;
  logic [31:0]   pc_addr, irF, irD, pcD, pc4D;
  logic [31:0]   w_pc_addr, w_irF, w_irD, w_pcD, w_pc4D;
  logic          validD, w_validD;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

  logic [31:0] imem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata   = imem[imem_addr];
  assign w_imem_rdata = imem[w_imem_addr];

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_addr(pc_addr), .irF(irF), .irD(irD), .pcD(pcD), .pc4D(pc4D),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
    .validD(validD)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(AW), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .pc_addr(w_pc_addr), .irF(w_irF), .irD(w_irD), .pcD(w_pcD), .pc4D(w_pc4D),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt(w_fetch_cnt), .stall_cnt(w_stall_cnt),
`endif
    .validD(w_validD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Behavioural model: architectural state of the fetch stage.
  logic [31:0] m_pc, m_ir, m_pcd, m_pc4d, m_fc, m_sc;
  logic        m_v;
  logic        m_ok = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return imem[(pc / 4) % 256];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_ir = NOP; m_pcd = 0; m_pc4d = 0; m_v = 0;
      m_fc = 0; m_sc = 0; m_ok = 1'b1;
    end else begin
      if (stall && !redirect) m_sc = m_sc + 1;
      if (redirect || flush) begin
        m_ir = NOP; m_v = 1'b0;
      end else if (!stall) begin
        m_ir = word_at(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 4; m_v = 1'b1;
        m_fc = m_fc + 1;
      end
      if (redirect) m_pc = (redirect_pc / 4) * 4;
      else if (!stall) m_pc = m_pc + 4;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_pc_addr", pc_addr, m_pc);
      chk("m_imem_addr", 32'(imem_addr), (m_pc / 4) % 256);
      chk("m_irF", irF, word_at(m_pc));
      chk("m_irD", irD, m_ir);
      chk("m_pcD", pcD, m_pcd);
      chk("m_pc4D", pc4D, m_pc4d);
      chk("m_validD", 32'(validD), 32'(m_v));
`ifdef IF_PERF_CNT_EN
      chk("m_fetch_cnt", fetch_cnt, m_fc);
      chk("m_stall_cnt", stall_cnt, m_sc);
`endif
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // T1 reset and first fetches
    tick; tick;
    chk("t1_pc_rst", pc_addr, 32'h0);
    chk("t1_valid_rst", 32'(validD), 32'h0);
    chk("t1_irD_rst", irD, NOP);
    chk("t1_pcD_rst", pcD, 32'h0);
    chk("t1_pc4D_rst", pc4D, 32'h0);
    chk("t1_irF_rst", irF, 32'h1000_0000);
    chk("t5_wrap_pc_rst", w_pc_addr, 32'hFFFF_FFFC);
    chk("t5_wrap_addr_rst", 32'(w_imem_addr), 32'hFF);
`ifdef IF_PERF_CNT_EN
    chk("t6_fc_rst", fetch_cnt, 32'h0);
    chk("t6_sc_rst", stall_cnt, 32'h0);
`endif
    rst = 1'b0;
    tick;
    chk("t1_pc_4", pc_addr, 32'h4);
    chk("t1_irD_0", irD, 32'h1000_0000);
    chk("t1_valid_1", 32'(validD), 32'h1);
    chk("t1_pc4D_4", pc4D, 32'h4);
    chk("t5_wrap_pc_0", w_pc_addr, 32'h0);
    chk("t5_wrap_addr_0", 32'(w_imem_addr), 32'h0);
    chk("t5_wrap_irD", w_irD, 32'h1000_00FF);
    tick;
    chk("t1_pc_8", pc_addr, 32'h8);
    chk("t1_irD_1", irD, 32'h1000_0001);
    chk("t1_pcD_4", pcD, 32'h4);
    chk("t1_pc4D_8", pc4D, 32'h8);

    // T2 stall for two cycles at pc 0x8
    stall = 1'b1;
    tick; tick;
    chk("t2_pc_hold", pc_addr, 32'h8);
    chk("t2_irD_hold", irD, 32'h1000_0001);
    stall = 1'b0;
    tick;
    chk("t2_pc_c", pc_addr, 32'hC);
    chk("t2_irD_2", irD, 32'h1000_0002);
    tick;
    chk("t3_pc_10", pc_addr, 32'h10);

    // T3 flush for one cycle at pc 0x10
    flush = 1'b1;
    tick;
    chk("t3_irD_nop", irD, NOP);
    chk("t3_valid_0", 32'(validD), 32'h0);
    chk("t3_pc_14", pc_addr, 32'h14);
    flush = 1'b0;
    tick;
    chk("t3_irD_5", irD, 32'h1000_0005);
    chk("t3_valid_1", 32'(validD), 32'h1);

    // T4 redirect together with stall
    redirect = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
    tick;
    chk("t4_pc_40", pc_addr, 32'h40);
    chk("t4_addr_10", 32'(imem_addr), 32'h10);
    chk("t4_valid_0", 32'(validD), 32'h0);
    redirect = 1'b0; stall = 1'b0;
    tick;
    chk("t4_irD_16", irD, 32'h1000_0010);

    // PC above the memory range wraps the word address
    redirect = 1'b1; redirect_pc = 32'h400;
    tick;
    chk("t5_pc_400", pc_addr, 32'h400);
    chk("t5_addr_400", 32'(imem_addr), 32'h0);
    redirect = 1'b0;
    tick;
    chk("t5_pcD_400", pcD, 32'h400);

    // Flush with stall: bubble wins, PC holds
    flush = 1'b1; stall = 1'b1;
    tick;
    chk("fs_pc_hold", pc_addr, 32'h404);
    chk("fs_valid_0", 32'(validD), 32'h0);
    chk("fs_pcD_hold", pcD, 32'h400);
    flush = 1'b0; stall = 1'b0;

    // Mixed control patterns, checked by the model
    for (int i = 0; i < 16; i++) begin
      stall       = (i % 3 == 1);
      flush       = (i % 5 == 2);
      redirect    = (i == 7) || (i == 12);
      redirect_pc = 32'h0000_0123 + 32'(i * 8);
      tick;
    end

    // Reset asserted mid-stall and mid-redirect
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; flush = 1'b0; rst = 1'b1;
    tick;
    chk("rr_pc_0", pc_addr, 32'h0);
    chk("rr_valid_0", 32'(validD), 32'h0);
    chk("rr_irD_nop", irD, NOP);
    chk("rr_pcD_0", pcD, 32'h0);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;

    // T6 ten cycles after reset, three of them stalled
    for (int i = 0; i < 10; i++) begin
      stall = (i == 2) || (i == 5) || (i == 8);
      tick;
    end
    stall = 1'b0;
`ifdef IF_PERF_CNT_EN
    chk("t6_fetch_7", fetch_cnt, 32'd7);
    chk("t6_stall_3", stall_cnt, 32'd3);
`endif
    chk("t6_pc_1c", pc_addr, 32'h1C);
    rst = 1'b1;
    tick;
`ifdef IF_PERF_CNT_EN
    chk("t6_fetch_clr", fetch_cnt, 32'h0);
    chk("t6_stall_clr", stall_cnt, 32'h0);
`endif
    chk("t6_pc_clr", pc_addr, 32'h0);
    rst = 1'b0;
    tick; tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
